// File: rtl/pdp_wdma_pack_if.sv
// pdp_wdma_pack_if: element stream in (pdp_dp2wdma) and packed DMA write request out
interface pdp_wdma_pack_if #(parameter int PACK_NUM = 8);
  logic                  pdp_dp2wdma_valid;
  logic                  pdp_dp2wdma_ready;
  logic [7:0]            pdp_dp2wdma_pd;
  logic                  dma_wr_req_valid;
  logic                  dma_wr_req_ready;
  logic [31:0]           dma_wr_req_addr;
  logic [PACK_NUM*8-1:0] dma_wr_req_data;
  logic [PACK_NUM-1:0]   dma_wr_req_mask;
  logic                  dma_wr_req_last;
  modport slave (
    input  pdp_dp2wdma_valid, pdp_dp2wdma_pd, dma_wr_req_ready,
    output pdp_dp2wdma_ready, dma_wr_req_valid, dma_wr_req_addr, dma_wr_req_data,
           dma_wr_req_mask, dma_wr_req_last
  );
  modport master (
    output pdp_dp2wdma_valid, pdp_dp2wdma_pd, dma_wr_req_ready,
    input  pdp_dp2wdma_ready, dma_wr_req_valid, dma_wr_req_addr, dma_wr_req_data,
           dma_wr_req_mask, dma_wr_req_last
  );
endinterface

// File: rtl/pdp_wdma_pack.sv
// pdp_wdma_pack: packs PDP output bytes into PACK_NUM-byte DMA write words with stride-based addressing
module pdp_wdma_pack #(
  parameter int PACK_NUM = 8
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           reg2dp_op_en,
  input  logic [12:0]    reg2dp_cube_out_width,
  input  logic [12:0]    reg2dp_cube_out_height,
  input  logic [12:0]    reg2dp_cube_out_channel,
  input  logic [31:0]    reg2dp_dst_base_addr,
  input  logic [31:0]    reg2dp_dst_line_stride,
  input  logic [31:0]    reg2dp_dst_surface_stride,
  pdp_wdma_pack_if.slave bus,
  output logic           wdma_busy,
  output logic           wdma_done
);
  localparam int LG = $clog2(PACK_NUM);
  localparam logic [31:0] AM = ~(32'(PACK_NUM) - 32'd1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [12:0] w, h, cm, x, y, c;
  logic [31:0] ls, ss, line_base, surf_base;
  logic [PACK_NUM*8-1:0] pack_data, nxt_data;
  logic [PACK_NUM-1:0] pack_mask, nxt_mask;
  logic [LG-1:0] lane;
  logic ready, accept, eol, last_elem, close;
  always_comb begin
    lane      = x[LG-1:0];
    ready     = state == RUN && (!bus.dma_wr_req_valid || bus.dma_wr_req_ready);
    accept    = ready && bus.pdp_dp2wdma_valid;
    eol       = x == w;
    last_elem = eol && y == h && c == cm;
    close     = accept && (eol || &lane);
    nxt_data  = pack_data | ((PACK_NUM*8)'(bus.pdp_dp2wdma_pd) << {lane, 3'b000});
    nxt_mask  = pack_mask | (PACK_NUM'(1) << lane);
  end
  assign bus.pdp_dp2wdma_ready = ready;
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state                <= IDLE;
      wdma_busy            <= 1'b0;
      wdma_done            <= 1'b0;
      {w, h, cm, x, y, c}  <= '0;
      {ls, ss}             <= '0;
      line_base            <= '0;
      surf_base            <= '0;
      pack_data            <= '0;
      pack_mask            <= '0;
      bus.dma_wr_req_valid <= 1'b0;
      bus.dma_wr_req_addr  <= '0;
      bus.dma_wr_req_data  <= '0;
      bus.dma_wr_req_mask  <= '0;
      bus.dma_wr_req_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (reg2dp_op_en) begin
          state     <= RUN;
          wdma_busy <= 1'b1;
          w         <= reg2dp_cube_out_width;
          h         <= reg2dp_cube_out_height;
          cm        <= reg2dp_cube_out_channel;
          ls        <= reg2dp_dst_line_stride & AM;
          ss        <= reg2dp_dst_surface_stride & AM;
          line_base <= reg2dp_dst_base_addr & AM;
          surf_base <= reg2dp_dst_base_addr & AM;
          {x, y, c} <= '0;
          pack_data <= '0;
          pack_mask <= '0;
        end
        RUN: if (accept && last_elem) state <= DRAIN;
        DRAIN: if (bus.dma_wr_req_ready) begin
          state     <= DONE;
          wdma_busy <= 1'b0;
          wdma_done <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          wdma_done <= 1'b0;
        end
      endcase
      if (bus.dma_wr_req_ready) bus.dma_wr_req_valid <= 1'b0;
      if (accept) begin
        pack_data <= close ? '0 : nxt_data;
        pack_mask <= close ? '0 : nxt_mask;
        if (eol) begin
          x <= '0;
          if (y < h) begin
            y         <= y + 13'd1;
            line_base <= line_base + ls;
          end else begin
            y         <= '0;
            c         <= c + 13'd1;
            surf_base <= surf_base + ss;
            line_base <= surf_base + ss;
          end
        end else x <= x + 13'd1;
        // A closing element loads the output slot; ready guarantees it is free or leaving
        if (close) begin
          bus.dma_wr_req_valid <= 1'b1;
          bus.dma_wr_req_addr  <= line_base + (32'(x) & AM);
          bus.dma_wr_req_data  <= nxt_data;
          bus.dma_wr_req_mask  <= nxt_mask;
          bus.dma_wr_req_last  <= last_elem;
        end
      end
    end
  end
endmodule

// File: tb/tb_pdp_wdma_pack.sv
// tb_pdp_wdma_pack: directed cubes with a word scoreboard popped by an independent monitor
module tb_pdp_wdma_pack;
  logic clk = 1'b0, rst = 1'b1, op_en = 1'b0;
  logic [12:0] width = '0, height = '0, channel = '0;
  logic [31:0] base = '0, lstride = '0, sstride = '0;
  logic busy, done;
  pdp_wdma_pack_if #(.PACK_NUM(8)) bus ();
  pdp_wdma_pack #(.PACK_NUM(8)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg2dp_op_en(op_en),
    .reg2dp_cube_out_width(width), .reg2dp_cube_out_height(height),
    .reg2dp_cube_out_channel(channel), .reg2dp_dst_base_addr(base),
    .reg2dp_dst_line_stride(lstride), .reg2dp_dst_surface_stride(sstride),
    .bus(bus), .wdma_busy(busy), .wdma_done(done)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic [63:0] d; logic [7:0] m; logic l;} word_t;
  word_t q[$];
  int errs = 0, checks = 0, done_cnt = 0, hs_cnt = 0, pop_cnt = 0, stall_cnt = 0;
  logic [31:0] last_a;
  logic [63:0] last_d;
  logic [7:0]  last_m;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  // Monitor: pops expected words on each handshake and polices stalls and done pulses
  initial begin
    logic stalled, prev_done;
    logic [31:0] sa;
    logic [63:0] sd;
    logic [7:0] sm;
    logic sl;
    word_t e;
    stalled = 0;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
        prev_done = 0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("done_width", 64'(prev_done), 64'd0);
        end
        prev_done = done;
        if (bus.pdp_dp2wdma_valid && bus.pdp_dp2wdma_ready) hs_cnt++;
        if (bus.dma_wr_req_valid && bus.dma_wr_req_ready) begin
          if (q.size() == 0) chk("word_unexpected", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("word_addr", 64'(bus.dma_wr_req_addr), 64'(e.a));
            chk("word_data", bus.dma_wr_req_data, e.d);
            chk("word_mask", 64'(bus.dma_wr_req_mask), 64'(e.m));
            chk("word_last", 64'(bus.dma_wr_req_last), 64'(e.l));
          end
          pop_cnt++;
          last_a = bus.dma_wr_req_addr;
          last_d = bus.dma_wr_req_data;
          last_m = bus.dma_wr_req_mask;
          stalled = 0;
        end else if (bus.dma_wr_req_valid) begin
          stall_cnt++;
          chk("stall_in_ready", 64'(bus.pdp_dp2wdma_ready), 64'd0);
          if (stalled)
            chk("stall_hold", {bus.dma_wr_req_addr, bus.dma_wr_req_mask, 7'd0, bus.dma_wr_req_last,
                16'(bus.dma_wr_req_data ^ sd)}, {sa, sm, 7'd0, sl, 16'd0});
          {sa, sd, sm, sl} = {bus.dma_wr_req_addr, bus.dma_wr_req_data, bus.dma_wr_req_mask, bus.dma_wr_req_last};
          stalled = 1;
        end else stalled = 0;
      end
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic put(input logic [7:0] d);
    int n;
    n = 0;
    bus.pdp_dp2wdma_valid = 1'b1;
    bus.pdp_dp2wdma_pd = d;
    @(negedge clk);
    while (!bus.pdp_dp2wdma_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("put_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask
  // Drives a cube and pushes the words it should produce; stop>0 aborts after that many elements
  task automatic run_cube(input int W, input int H, input int C, input logic [31:0] b,
                          input logic [31:0] ls, input logic [31:0] ss, input int stop, input bit tog);
    logic [63:0] d;
    logic [7:0] m, v;
    logic [31:0] la;
    int n, lane;
    width = 13'(W);
    height = 13'(H);
    channel = 13'(C);
    base = b;
    lstride = ls;
    sstride = ss;
    op_en = 1'b1;
    @(posedge clk);
    #1;
    op_en = 1'b0;
    n = 0;
    d = '0;
    m = '0;
    for (int c = 0; c <= C; c++)
      for (int y = 0; y <= H; y++)
        for (int x = 0; x <= W; x++) begin
          v = 8'((n + 1) * 17);
          op_en = tog & x[0];
          put(v);
          lane = x % 8;
          la = (b & ~32'd7) + 32'(c) * (ss & ~32'd7) + 32'(y) * (ls & ~32'd7);
          d[lane*8 +: 8] = v;
          m[lane] = 1'b1;
          if (lane == 7 || x == W) begin
            q.push_back('{la + 32'((x / 8) * 8), d, m, x == W && y == H && c == C});
            d = '0;
            m = '0;
          end
          n++;
          if (stop > 0 && n == stop) return;
        end
    bus.pdp_dp2wdma_valid = 1'b0;
    op_en = 1'b0;
  endtask
  task automatic finish_cube(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'(prev + 1));
    chk("words_left", 64'(q.size()), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask
  initial begin
    int prev;
    bus.pdp_dp2wdma_valid = 1'b0;
    bus.pdp_dp2wdma_pd = '0;
    bus.dma_wr_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {60'd0, bus.dma_wr_req_valid, bus.pdp_dp2wdma_ready, busy, done}, 64'd0);
    chk("reset_data", bus.dma_wr_req_data, 64'd0);
    chk("reset_addr", {23'd0, bus.dma_wr_req_last, bus.dma_wr_req_mask, bus.dma_wr_req_addr}, 64'd0);
    @(posedge clk);
    #1;
    // Single short line, done timing relative to last element
    prev = done_cnt;
    run_cube(3, 0, 0, 32'h1000, 0, 0, 0, 0);
    @(negedge clk);
    chk("done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("done_timing", 64'(done), 64'd1);
    finish_cube(prev);
    chk("t1_addr", 64'(last_a), 64'h1000);
    chk("t1_data", last_d, 64'h0000_0000_4433_2211);
    chk("t1_mask", 64'(last_m), 64'h0F);
    // Two lines with partial tail words
    prev = done_cnt;
    pop_cnt = 0;
    run_cube(9, 1, 0, 32'h2000, 32'h100, 0, 0, 0);
    finish_cube(prev);
    chk("t2_words", 64'(pop_cnt), 64'd4);
    chk("t2_last_addr", 64'(last_a), 64'h2108);
    chk("t2_last_mask", 64'(last_m), 64'h03);
    // Three surfaces
    prev = done_cnt;
    hs_cnt = 0;
    run_cube(7, 0, 2, 32'h0, 0, 32'h400, 0, 0);
    finish_cube(prev);
    chk("t3_handshakes", 64'(hs_cnt), 64'd24);
    chk("t3_last_addr", 64'(last_a), 64'h800);
    // Backpressure on the first word
    prev = done_cnt;
    pop_cnt = 0;
    stall_cnt = 0;
    fork
      run_cube(31, 0, 0, 32'h5000, 0, 0, 0, 0);
      begin
        int n;
        n = 0;
        while (!bus.dma_wr_req_valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        bus.dma_wr_req_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.dma_wr_req_ready = 1'b1;
      end
    join
    finish_cube(prev);
    chk("t4_words", 64'(pop_cnt), 64'd4);
    chk("t4_stalled", 64'(stall_cnt >= 4), 64'd1);
    // Reset mid-cube, then a clean restart
    prev = done_cnt;
    run_cube(31, 0, 0, 32'h6000, 0, 0, 10, 0);
    rst = 1'b1;
    bus.pdp_dp2wdma_valid = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {60'd0, bus.dma_wr_req_valid, bus.pdp_dp2wdma_ready, busy, done}, 64'd0);
    chk("rst_word", {bus.dma_wr_req_addr, 23'd0, bus.dma_wr_req_last, bus.dma_wr_req_mask}, 64'd0);
    chk("rst_data", bus.dma_wr_req_data, 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt), 64'(prev));
    @(posedge clk);
    #1;
    run_cube(31, 0, 0, 32'h3000, 0, 0, 0, 0);
    finish_cube(prev);
    chk("restart_last_addr", 64'(last_a), 64'h3018);
    // Misaligned base, single element
    prev = done_cnt;
    run_cube(0, 0, 0, 32'h1005, 0, 0, 0, 0);
    finish_cube(prev);
    chk("t6_addr", 64'(last_a), 64'h1000);
    chk("t6_mask", 64'(last_m), 64'h01);
    chk("t6_data", last_d, 64'h11);
    // op_en toggling while running
    prev = done_cnt;
    run_cube(15, 1, 0, 32'h7000, 32'h80, 0, 0, 1);
    finish_cube(prev);
    chk("t7_last_addr", 64'(last_a), 64'h7088);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
